spi_mem_slave_ctrl: RTL

// SPI slave front-end (mode 0, MSB first) driving the 16x8 register memory port. Decodes a
// 2-byte frame (command + data) from an external master into single-cycle mem_we / mem_re /
// mem_initial strobes and returns read data on MISO. Sits between the pads and the memory,
// all logic in the mem_clk domain; sck/cs_n/mosi are asynchronous and synchronized here.

---
 rtl/spi_mem_slave_ctrl.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/spi_mem_slave_ctrl.sv
// spi_mem_slave_ctrl
// SPI mode-0 slave (MSB first) in front of a 16x8 register memory. A frame is
// a command byte followed by a data byte. Bit 7 of the command selects read,
// bit 6 selects init (and wins over bit 7), and bits 3:0 carry the address.
// Each frame turns into one single-cycle mem_we, mem_re or mem_initial strobe.
// All logic runs on mem_clk. sck, cs_n and mosi are synchronized on entry.
// Ports:
//   mem_clk, mem_rst_n       : system clock, async active-low reset
//   sck, cs_n, mosi          : async SPI pad inputs
//   miso, miso_oe            : read data out, driven only while returning data
//   mem_en                   : high while a frame is in progress
//   mem_address, buffer_rx   : memory address / write data (held between frames)
//   buffer_tx                : memory read data, valid one cycle after mem_re
//   mem_we, mem_re, mem_initial : one-cycle memory strobes
//   frame_cnt                : count of completed frames, wraps at 8 bits
module spi_mem_slave_ctrl #(
  parameter int SYNC_STAGES = 2,
  parameter int ADDR_W      = 4,
  parameter int DATA_W      = 8
) (
  input  logic              mem_clk,
  input  logic              mem_rst_n,
  input  logic              sck,
  input  logic              cs_n,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] buffer_rx,
  input  logic [DATA_W-1:0] buffer_tx,
  output logic              mem_we,
  output logic              mem_re,
  output logic              mem_initial,
  output logic [7:0]        frame_cnt
);
  localparam int CNT_W = $clog2(DATA_W);

  typedef enum logic [2:0] {
    IDLE, CMD, WR_DATA, RD_ISSUE, RD_LOAD, RD_DATA, DONE, WAIT_CS
  } state_e;

  state_e                  state_q, state_d;
  logic [SYNC_STAGES-1:0]  sck_sync_q, sck_sync_d;
  logic [SYNC_STAGES-1:0]  cs_sync_q, cs_sync_d;
  logic [SYNC_STAGES-1:0]  mosi_sync_q, mosi_sync_d;
  logic                    sck_prev_q, sck_prev_d, cs_prev_q, cs_prev_d;
  logic [CNT_W-1:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0]       rx_sr_q, rx_sr_d, tx_sr_q, tx_sr_d;
  logic [DATA_W-1:0]       buffer_rx_q, buffer_rx_d;
  logic [ADDR_W-1:0]       addr_q, addr_d;
  logic                    we_q, we_d, re_q, re_d, init_q, init_d;
  logic [7:0]              frame_cnt_q, frame_cnt_d;

  logic              sck_s, cs_s, mosi_s;
  logic              sck_rise, sck_fall, cs_fall, last_bit;
  logic [DATA_W-1:0] rx_byte;

  assign sck_s    = sck_sync_q[SYNC_STAGES-1];
  assign cs_s     = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_prev_q & ~cs_s;
  assign sck_fall = ~sck_s & sck_prev_q & ~cs_s;
  assign cs_fall  = cs_prev_q & ~cs_s;
  assign last_bit = (bit_cnt_q == CNT_W'(DATA_W - 1));
  assign rx_byte  = {rx_sr_q[DATA_W-2:0], mosi_s};

  always_comb begin
    sck_sync_d  = {sck_sync_q[SYNC_STAGES-2:0], sck};
    cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], cs_n};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
    sck_prev_d  = sck_s;
    cs_prev_d   = cs_s;
  end

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    rx_sr_d     = rx_sr_q;
    tx_sr_d     = tx_sr_q;
    buffer_rx_d = buffer_rx_q;
    addr_d      = addr_q;
    we_d        = 1'b0;
    re_d        = 1'b0;
    init_d      = 1'b0;
    frame_cnt_d = frame_cnt_q;
    case (state_q)
      IDLE: begin
        bit_cnt_d = '0;
        if (cs_fall) state_d = CMD;
      end
      CMD, WR_DATA: begin
        if (cs_s) begin
          state_d = IDLE;
        end else if (sck_rise) begin
          rx_sr_d   = rx_byte;
          bit_cnt_d = last_bit ? '0 : bit_cnt_q + 1'b1;
          if (last_bit && state_q == CMD) begin
            addr_d = rx_byte[ADDR_W-1:0];
            if (rx_byte[DATA_W-2]) begin
              init_d  = 1'b1;
              state_d = DONE;
            end else if (rx_byte[DATA_W-1]) begin
              // Strobe is registered, so mem_re is high during RD_ISSUE and
              // the memory answers during RD_LOAD.
              re_d    = 1'b1;
              state_d = RD_ISSUE;
            end else begin
              state_d = WR_DATA;
            end
          end else if (last_bit) begin
            buffer_rx_d = rx_byte;
            we_d        = 1'b1;
            state_d     = DONE;
          end
        end
      end
      RD_ISSUE: state_d = cs_s ? IDLE : RD_LOAD;
      RD_LOAD: begin
        if (cs_s) begin
          state_d = IDLE;
        end else begin
          tx_sr_d = buffer_tx;
          state_d = RD_DATA;
        end
      end
      RD_DATA: begin
        if (cs_s) begin
          state_d = IDLE;
        end else begin
          // The fall right after the command byte arrives with the count at 0;
          // skipping it keeps the MSB on MISO for the first data rise.
          if (sck_fall && bit_cnt_q != '0) tx_sr_d = {tx_sr_q[DATA_W-2:0], 1'b0};
          if (sck_rise) begin
            bit_cnt_d = last_bit ? '0 : bit_cnt_q + 1'b1;
            if (last_bit) state_d = DONE;
          end
        end
      end
      DONE: begin
        bit_cnt_d   = '0;
        frame_cnt_d = frame_cnt_q + 8'd1;
        state_d     = WAIT_CS;
      end
      WAIT_CS: begin
        bit_cnt_d = '0;
        if (cs_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge mem_clk or negedge mem_rst_n) begin
    if (!mem_rst_n) begin
      state_q     <= IDLE;
      sck_sync_q  <= '0;
      // cs_n resets as "selected" so a select held low across reset never
      // looks like a fresh falling edge; a new frame needs cs_n high first.
      cs_sync_q   <= '0;
      mosi_sync_q <= '0;
      sck_prev_q  <= 1'b0;
      cs_prev_q   <= 1'b0;
      bit_cnt_q   <= '0;
      rx_sr_q     <= '0;
      tx_sr_q     <= '0;
      buffer_rx_q <= '0;
      addr_q      <= '0;
      we_q        <= 1'b0;
      re_q        <= 1'b0;
      init_q      <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      sck_sync_q  <= sck_sync_d;
      cs_sync_q   <= cs_sync_d;
      mosi_sync_q <= mosi_sync_d;
      sck_prev_q  <= sck_prev_d;
      cs_prev_q   <= cs_prev_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_sr_q     <= rx_sr_d;
      tx_sr_q     <= tx_sr_d;
      buffer_rx_q <= buffer_rx_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      re_q        <= re_d;
      init_q      <= init_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign miso        = (state_q == RD_DATA) ? tx_sr_q[DATA_W-1] : 1'b0;
  assign miso_oe     = (state_q == RD_DATA);
  assign mem_en      = (state_q != IDLE);
  assign mem_address = addr_q;
  assign buffer_rx   = buffer_rx_q;
  assign mem_we      = we_q;
  assign mem_re      = re_q;
  assign mem_initial = init_q;
  assign frame_cnt   = frame_cnt_q;
endmodule
